// File: rtl/mul_div_unit.sv
// Purpose : iterative 32-bit multiply/divide unit. Shift-add multiply and restoring
//           divide, one bit per cycle. Results feed the register bank LO/HI write path.
// Latency : 33 cycles from the accepting edge to done; 1 cycle for divide-by-zero.
// Backpressure: none. start is sampled only in IDLE. A start while busy is dropped, not queued.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start, op    request; op = 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend and multiplier/divisor (sampled on accept)
//   busy, done   operation in flight; one-cycle completion pulse
//   lo, hi       product low/high word, or quotient/remainder (held between dones)
//   dz           divide-by-zero flag, valid with done, held until next accept
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 div_q, div_d;        // 1: divide, 0: multiply
  logic                 zdiv_q, zdiv_d;      // zero-divisor path pending in FIX
  logic                 neg_lo_q, neg_lo_d;  // negate product / quotient
  logic                 neg_hi_q, neg_hi_d;  // negate remainder (dividend sign)
  logic [WIDTH-1:0]     opnd_q, opnd_d;      // multiplicand magnitude or divisor magnitude
  // Multiply: {carry, hi, lo/multiplier}. Divide: {remainder (33b), quotient/dividend}.
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;

  // Combinational temporaries
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      zdiv_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      zdiv_q   <= zdiv_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    zdiv_d   = zdiv_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    lo_d     = lo_q;
    hi_d     = hi_q;

    // op[0]=0 selects the signed variants
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          div_d    = op[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = '0;
          dz_d     = 1'b0;
          zdiv_d   = 1'b0;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{(WIDTH+1){1'b0}}, mag_a};
            if (b == '0) begin
              // Keep the raw dividend; it is returned unmodified in hi.
              zdiv_d  = 1'b1;
              acc_d   = {{(WIDTH+1){1'b0}}, a};
              state_d = FIX;
            end else begin
              state_d = RUN;
            end
          end else begin
            opnd_d  = mag_a;
            acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (div_q) begin
          // Bring the next dividend bit into the remainder, then trial-subtract.
          // The remainder stays below the divisor, so its top acc bit is always zero.
          shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          diff    = shifted - {1'b0, opnd_q};
          if (!diff[WIDTH]) begin
            acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {shifted, acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Add into the upper half keeping the carry, then shift the carry down.
          sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
          acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (zdiv_q) begin
          lo_d = '1;
          hi_d = acc_q[WIDTH-1:0];
          dz_d = 1'b1;
        end else if (div_q) begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_lo_q ? -quo : quo;
          hi_d = neg_hi_q ? -rem : rem;
        end else begin
          prod = acc_q[2*WIDTH-1:0];
          if (neg_lo_q) begin
            prod = -prod;
          end
          lo_d = prod[WIDTH-1:0];
          hi_d = prod[2*WIDTH-1:WIDTH];
        end
        zdiv_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset state, signed/unsigned multiply and divide,
// divide-by-zero, dropped start while busy, and reset abort mid-operation.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] lo, hi;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lo    (lo),
    .hi    (hi),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then watch until done within a bounded number of edges.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edz, input string tag);
    int          n;
    bit          got;
    bit          steady;
    logic [31:0] prev_lo, prev_hi;
    @(negedge clk);
    prev_lo = lo;
    prev_hi = hi;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    check({tag, " busy_e0"}, 64'(busy), 64'd1);
    check({tag, " dz_clr_e0"}, 64'(dz), 64'd0);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    n = 0; got = 0; steady = 1;
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (!busy || lo !== prev_lo || hi !== prev_hi) steady = 0;
    end
    check({tag, " timeout"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " hold_busy"}, 64'(steady), 64'd1);
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " dz"}, 64'(dz), 64'(edz));
    check({tag, " busy_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    int first;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz",   64'(dz),   64'd0);
    check("rst lo",   64'(lo),   64'd0);
    check("rst hi",   64'(hi),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0, "multu_max");
    do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 33, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, "mult_neg");
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 33, 32'h00000000, 32'h40000000, 1'b0, "mult_min");
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "div_neg");
    do_op(OP_DIVU,  32'h00000007, 32'h00000002, 33, 32'h00000003, 32'h00000001, 1'b0, "divu_7_2");
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, 1'b0, "div_ovf");
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000000, 1,  32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, "div_dz");
    do_op(OP_DIVU,  32'd100,      32'h00000000, 1,  32'hFFFFFFFF, 32'd100,      1'b1, "divu_dz");
    do_op(OP_MULTU, 32'd2,        32'd3,        33, 32'd6,        32'd0,        1'b0, "multu_after_dz");

    // A start pulsed while busy must be dropped.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    ndone = 0; first = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("ign done_count", 64'(ndone), 64'd1);
    check("ign latency",    64'(first), 64'd33);
    check("ign lo",         64'(lo),    64'd6);
    check("ign hi",         64'(hi),    64'd0);
    check("ign busy",       64'(busy),  64'd0);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort lo",   64'(lo),   64'd0);
    check("abort hi",   64'(hi),   64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no_done", 64'(ndone), 64'd0);

    do_op(OP_DIVU, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, "divu_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
